// File: rtl/pix_scan_gen_if.sv
// Pixel beat stream between the scan generator and its consumer.
interface pix_scan_gen_if #(
   parameter int unsigned NUM_X_BITS = 10,
   parameter int unsigned NUM_Y_BITS = 10,
   parameter int unsigned LANES      = 4
);
   logic                  out_valid;
   logic                  out_ready;
   logic [NUM_X_BITS-1:0] out_x;
   logic [NUM_Y_BITS-1:0] out_y;
   logic [LANES-1:0]      out_mask;
   logic                  out_last;

   modport master (
      output out_valid, out_x, out_y, out_mask, out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid, out_x, out_y, out_mask, out_last,
      output out_ready
   );
endinterface

// File: rtl/pix_scan_gen.sv
// Raster scan generator: walks a frame row by row, LANES pixels per beat.
module pix_scan_gen #(
   parameter int unsigned NUM_X_BITS = 10,
   parameter int unsigned NUM_Y_BITS = 10,
   parameter int unsigned LANES      = 4
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [NUM_X_BITS-1:0] x_max,
   input  logic [NUM_Y_BITS-1:0] y_max,
   output logic                  busy,
   output logic                  done,
   pix_scan_gen_if.master        bus
);

   // One extra bit so x+LANES never wraps at the top of the x range.
   localparam int unsigned XW1 = NUM_X_BITS + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                state;
   logic [NUM_X_BITS-1:0] x_lim;
   logic [NUM_Y_BITS-1:0] y_lim;

   logic [XW1-1:0]        x_sum;
   logic                  row_end;
   logic [NUM_X_BITS-1:0] adv_x;
   logic [NUM_Y_BITS-1:0] adv_y;
   logic [LANES-1:0]      adv_mask;
   logic                  adv_last;

   // Lanes whose pixel column lies inside the frame.
   function automatic logic [LANES-1:0] lane_mask(input logic [NUM_X_BITS-1:0] x,
                                                  input logic [NUM_X_BITS-1:0] xm);
      logic [LANES-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         m[i] = (({1'b0, x} + XW1'(i)) <= {1'b0, xm});
      end
      return m;
   endfunction

   // Beat at (x, y) is the final one of the frame.
   function automatic logic is_last(input logic [NUM_X_BITS-1:0] x,
                                    input logic [NUM_Y_BITS-1:0] y,
                                    input logic [NUM_X_BITS-1:0] xm,
                                    input logic [NUM_Y_BITS-1:0] ym);
      return (y == ym) && (({1'b0, x} + XW1'(LANES)) > {1'b0, xm});
   endfunction

   // Position and attributes of the beat following the current one.
   always_comb begin
      x_sum    = {1'b0, bus.out_x} + XW1'(LANES);
      row_end  = (x_sum > {1'b0, x_lim});
      adv_x    = row_end ? '0 : x_sum[NUM_X_BITS-1:0];
      adv_y    = row_end ? NUM_Y_BITS'(bus.out_y + NUM_Y_BITS'(1)) : bus.out_y;
      adv_mask = lane_mask(adv_x, x_lim);
      adv_last = is_last(adv_x, adv_y, x_lim, y_lim);
   end

   // Scan FSM with registered beat, busy and done outputs.
   always_ff @(posedge clk) begin
      if (!n_rst || abort) begin
         state         <= IDLE;
         busy          <= 1'b0;
         done          <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out_x     <= '0;
         bus.out_y     <= '0;
         bus.out_mask  <= '0;
         bus.out_last  <= 1'b0;
         if (!n_rst) begin
            x_lim <= '0;
            y_lim <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state         <= RUN;
                  x_lim         <= x_max;
                  y_lim         <= y_max;
                  busy          <= 1'b1;
                  bus.out_valid <= 1'b1;
                  bus.out_x     <= '0;
                  bus.out_y     <= '0;
                  bus.out_mask  <= lane_mask('0, x_max);
                  bus.out_last  <= is_last('0, '0, x_max, y_max);
               end
            end
            RUN: begin
               if (bus.out_valid && bus.out_ready) begin
                  if (bus.out_last) begin
                     state         <= DONE;
                     busy          <= 1'b0;
                     done          <= 1'b1;
                     bus.out_valid <= 1'b0;
                     bus.out_x     <= '0;
                     bus.out_y     <= '0;
                     bus.out_mask  <= '0;
                     bus.out_last  <= 1'b0;
                  end else begin
                     bus.out_x    <= adv_x;
                     bus.out_y    <= adv_y;
                     bus.out_mask <= adv_mask;
                     bus.out_last <= adv_last;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: begin
               state         <= IDLE;
               busy          <= 1'b0;
               done          <= 1'b0;
               bus.out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/pix_scan_gen.md
PIX_SCAN_GEN -- requirements
Module: pix_scan_gen

Interface
REQ-001 Parameter NUM_X_BITS, default 10, width of x coordinate and x bound.
REQ-002 Parameter NUM_Y_BITS, default 10, width of y coordinate and y bound.
REQ-003 Parameter LANES, default 4, pixels per output beat, range 1..2**NUM_X_BITS.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 n_rst  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  begin a frame scan; sampled only in IDLE.
REQ-007 abort  input  1  terminate scan immediately; priority over start.
REQ-008 x_max  input  NUM_X_BITS  inclusive last x column; sampled on accepted start.
REQ-009 y_max  input  NUM_Y_BITS  inclusive last y row; sampled on accepted start.
REQ-010 out_ready  input  1  downstream accepts current beat.
REQ-011 out_valid  output  1  beat on out_x/out_y/out_mask/out_last is valid.
REQ-012 out_x  output  NUM_X_BITS  x of lane 0 of current beat.
REQ-013 out_y  output  NUM_Y_BITS  row of current beat.
REQ-014 out_mask  output  LANES  bit i set when pixel out_x+i is inside the frame.
REQ-015 out_last  output  1  current beat is final beat of frame.
REQ-016 busy  output  1  high in RUN.
REQ-017 done  output  1  one-cycle pulse after final beat accepted.

Function
REQ-018 States SHALL be IDLE, RUN, DONE; all outputs registered.
REQ-019 IDLE: start=1 and abort=0 -> latch x_max/y_max, x=0, y=0, go RUN; out_valid high the following cycle (latency 1).
REQ-020 RUN: out_valid=1 continuously; beat accepted when out_valid && out_ready.
REQ-021 While out_valid && !out_ready, out_x, out_y, out_mask, out_last SHALL hold stable.
REQ-022 Accepted beat, x+LANES <= latched x_max: x advances by LANES, y unchanged.
REQ-023 Accepted beat, x+LANES > latched x_max, y < latched y_max: x=0, y increments.
REQ-024 Accepted beat with out_last=1: go DONE; out_valid low next cycle.
REQ-025 x+LANES SHALL be computed in NUM_X_BITS+1 bits; no wrap at x_max = 2**NUM_X_BITS-1.
REQ-026 out_mask[i] = 1 iff x+i <= latched x_max (NUM_X_BITS+1 bit compare); lane 0 always set in RUN.
REQ-027 out_last = 1 iff y == latched y_max and x+LANES > latched x_max.
REQ-028 DONE: done=1 for exactly one cycle, then IDLE unconditionally.
REQ-029 start in RUN or DONE SHALL be ignored; x_max/y_max changes after start SHALL not affect the scan.
REQ-030 abort=1 in any state -> IDLE next cycle, out_valid=0, done not pulsed, busy=0.
REQ-031 abort and start same cycle in IDLE -> remain IDLE.
REQ-032 Beat accepted in same cycle as abort SHALL be the last beat issued; no further beats.
REQ-033 Outside RUN, out_x, out_y, out_mask, out_last SHALL be 0.
REQ-034 x_max=0, y_max=0 SHALL produce exactly one beat: out_x=0, out_y=0, out_mask=1, out_last=1.

Reset
REQ-035 n_rst=0 at a rising edge -> state IDLE, x=0, y=0, latched bounds 0.
REQ-036 Reset values: out_valid=0, out_x=0, out_y=0, out_mask=0, out_last=0, busy=0, done=0.
REQ-037 Reset SHALL override start, abort and out_ready, including mid-scan; no done pulse.
REQ-038 First start honoured on the first edge with n_rst=1.

Verification
REQ-039 LANES=4, x_max=9, y_max=1, out_ready=1, start pulse -> beats (0,0,1111),(4,0,1111),(8,0,0011),(0,1,1111),(4,1,1111),(8,1,0011, last); done one cycle after; 6 beats total.
REQ-040 Same config, out_ready toggled pseudo-randomly -> identical beat sequence, outputs stable during stalls, no beat lost or duplicated.
REQ-041 x_max=0, y_max=0 -> single beat out_mask=0001, out_last=1, done pulse.
REQ-042 NUM_X_BITS=4, LANES=4, x_max=15, y_max=0 -> beats x=0,4,8,12 all mask 1111, last on x=12, no overflow wrap.
REQ-043 abort asserted on third beat while stalled -> out_valid=0 next cycle, no done, busy=0; subsequent start restarts at (0,0).
REQ-044 n_rst=0 mid-scan with start held -> all outputs 0, IDLE; after release, start begins new frame at (0,0) with newly sampled bounds.
